// File: rtl/sseg_mux_disp.sv
// ============================================================================
// sseg_mux_disp : time-multiplexed common-anode 7-segment driver with
//                 frame-synchronous shadow registers and leading-zero blanking
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sseg_mux_disp #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic [4*N_DIGITS-1:0] iHEX,
    input  logic [N_DIGITS-1:0]   iDP,
    input  logic                  iBLANK_EN,
    input  logic                  iLOAD,
    output logic [N_DIGITS-1:0]   oAN,
    output logic [6:0]            oSSEG,
    output logic                  oDP,
    output logic                  oFRAME
);

    localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);

    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    logic [c_IDX_W-1:0]    idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_hex_q, pend_hex_d, act_hex_q, act_hex_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                  pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  wrap_q;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            sseg_q, sseg_d;
    logic                  dp_q, dp_d;
    logic                  frame_q;

    logic                  tick, wrap, blank_cur, lz_acc;
    logic [N_DIGITS-1:0]   lz;
    logic [3:0]            nib;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            default: hex2seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick  = (cnt_q == c_CNT_LAST);
        wrap  = tick && (idx_q == c_IDX_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Active set only moves on a frame boundary; a load on that same cycle
    // goes straight to active so it is not delayed by a whole frame.
    always_comb begin
        pend_hex_d   = pend_hex_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        act_hex_d    = act_hex_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (wrap) begin
            if (iLOAD) begin
                act_hex_d   = iHEX;
                act_dp_d    = iDP;
                act_blank_d = iBLANK_EN;
            end else if (pend_vld_q) begin
                act_hex_d   = pend_hex_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
            pend_vld_d = 1'b0;
        end else if (iLOAD) begin
            pend_hex_d   = iHEX;
            pend_dp_d    = iDP;
            pend_blank_d = iBLANK_EN;
            pend_vld_d   = 1'b1;
        end
    end

    // lz[k] = digit k and every digit above it are zero
    always_comb begin
        lz     = '0;
        lz_acc = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            lz_acc = lz_acc & (act_hex_q[4*k +: 4] == 4'h0);
            lz[k]  = lz_acc;
        end
        nib       = act_hex_q[4*idx_q +: 4];
        blank_cur = act_blank_q && (idx_q != '0) && lz[idx_q];
        an_d      = ~(N_DIGITS'(1) << idx_q);
        sseg_d    = blank_cur ? 7'h7F : hex2seg(nib);
        dp_d      = ~act_dp_q[idx_q];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_hex_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= 1'b0;
            pend_vld_q   <= 1'b0;
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= 1'b0;
            wrap_q       <= 1'b0;
            an_q         <= '1;
            sseg_q       <= 7'h7F;
            dp_q         <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_hex_q   <= pend_hex_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            act_hex_q    <= act_hex_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            wrap_q       <= wrap;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            frame_q      <= wrap_q;
        end
    end

    assign oAN    = an_q;
    assign oSSEG  = sseg_q;
    assign oDP    = dp_q;
    assign oFRAME = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_mux_disp.sv
// ============================================================================
// tb_sseg_mux_disp : scoreboard bench for sseg_mux_disp (N=4, REFRESH=4)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sseg_mux_disp;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic [15:0] iHEX;
    logic [3:0]  iDP;
    logic        iBLANK_EN;
    logic        iLOAD;
    logic [3:0]  oAN;
    logic [6:0]  oSSEG;
    logic        oDP;
    logic        oFRAME;

    sseg_mux_disp #(.N_DIGITS(4), .REFRESH_CYCLES(4)) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iHEX      (iHEX),
        .iDP       (iDP),
        .iBLANK_EN (iBLANK_EN),
        .iLOAD     (iLOAD),
        .oAN       (oAN),
        .oSSEG     (oSSEG),
        .oDP       (oDP),
        .oFRAME    (oFRAME)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_reset(input int n);
        exp_t e;
        e = '{an: 4'hF, sseg: 7'h7F, dp: 1'b1, fr: 1'b0};
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Expected outputs for the first nslots cycles of a frame (4 per digit)
    task automatic push_frame(input logic [15:0] hex, input logic [3:0] dpv,
                              input logic blank, input logic pulse, input int nslots);
        exp_t e;
        int   top;
        int   d;
        logic [3:0] nb;
        top = -1;
        for (int k = 0; k < 4; k++) begin
            nb = hex[4*k +: 4];
            if (nb != 4'h0) top = k;
        end
        for (int j = 0; j < nslots; j++) begin
            d      = j / 4;
            nb     = hex[4*d +: 4];
            e.an   = ~(4'b0001 << d);
            e.sseg = (blank && d >= 1 && d > top) ? 7'h7F : seg_tbl[nb];
            e.dp   = ~dpv[d];
            e.fr   = pulse && (j == 0);
            sb.push_back(e);
        end
    endtask

    task automatic clk_step();
        exp_t e;
        @(posedge iCLK);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("oAN",    {12'h0, oAN},   {12'h0, e.an});
            chk("oSSEG",  {9'h0, oSSEG},  {9'h0, e.sseg});
            chk("oDP",    {15'h0, oDP},   {15'h0, e.dp});
            chk("oFRAME", {15'h0, oFRAME}, {15'h0, e.fr});
        end
    endtask

    // Runs n cycles of a frame; optional loads land on the edge of slot a1/a2
    task automatic do_frame(input int n, input int a1, input logic [15:0] h1,
                            input int a2, input logic [15:0] h2,
                            input logic [3:0] dpl, input logic bl);
        for (int j = 0; j < n; j++) begin
            iLOAD     = 1'b0;
            iHEX      = 16'($urandom);
            iDP       = 4'($urandom);
            iBLANK_EN = 1'($urandom);
            if (j == a1) begin
                iLOAD = 1'b1; iHEX = h1; iDP = dpl; iBLANK_EN = bl;
            end
            if (j == a2) begin
                iLOAD = 1'b1; iHEX = h2; iDP = dpl; iBLANK_EN = bl;
            end
            clk_step();
        end
        iLOAD = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] h;
        iRESET = 1'b1; iLOAD = 1'b0; iHEX = '0; iDP = '0; iBLANK_EN = 1'b0;
        push_reset(3);
        for (int i = 0; i < 3; i++) clk_step();
        iRESET = 1'b0;

        // frame 0: reset contents, no pulse; mid-frame load must not tear
        push_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 16);
        do_frame(16, 5, 16'h1A2F, -1, 16'h0, 4'b0100, 1'b0);
        push_frame(16'h1A2F, 4'b0100, 1'b0, 1'b1, 16);
        do_frame(16, 7, 16'h0050, -1, 16'h0, 4'b0000, 1'b1);
        push_frame(16'h0050, 4'b0000, 1'b1, 1'b1, 16);
        do_frame(16, 3, 16'h0000, -1, 16'h0, 4'b1000, 1'b1);
        // all-zero with blanking; digit 3 blank but its DP still lit
        push_frame(16'h0000, 4'b1000, 1'b1, 1'b1, 16);
        do_frame(16, 2, 16'h9999, 10, 16'h1234, 4'b0000, 1'b0);
        push_frame(16'h1234, 4'b0000, 1'b0, 1'b1, 16);
        do_frame(16, 15, 16'h5678, -1, 16'h0, 4'b0000, 1'b0);
        push_frame(16'h5678, 4'b0000, 1'b0, 1'b1, 16);
        do_frame(16, 15, 16'h0000, -1, 16'h0, 4'b0000, 1'b0);

        // nibble sweep, each loaded on the wrap-tick cycle of the prior frame
        for (int v = 0; v < 16; v++) begin
            h = {4{4'(v)}};
            push_frame(h, 4'b0000, 1'b0, 1'b1, 16);
            h = {4{4'(v + 1)}};
            do_frame(16, (v < 15) ? 15 : -1, h, -1, 16'h0, 4'b0000, 1'b0);
        end

        // reset mid-frame with a pending load: it must be discarded
        push_frame(16'hFFFF, 4'b0000, 1'b0, 1'b1, 9);
        do_frame(9, 5, 16'h8888, -1, 16'h0, 4'b1111, 1'b0);
        iRESET = 1'b1;
        push_reset(2);
        clk_step();
        clk_step();
        iRESET = 1'b0;
        push_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 16);
        do_frame(16, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
        push_frame(16'h0000, 4'b0000, 1'b0, 1'b1, 16);
        do_frame(16, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
